led_status_arbiter: RTL and testbench

//   Shares the five board LEDs between NUM_REQ status requesters (SPI engine, SD init, error, ...).

---
 rtl/led_ctrl_pkg.sv | 14 +
 rtl/led_tick_gen.sv | 29 ++
 rtl/led_status_arbiter.sv | 122 ++++++++++++
 tb/tb_led_status_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED status arbiter.
// prio_first picks the one-hot lowest set bit, i.e. the highest-priority requester.
package led_ctrl_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  localparam int LED_W   = 5;
  localparam int MAX_REQ = 32;

  function automatic logic [MAX_REQ-1:0] prio_first(input logic [MAX_REQ-1:0] vec);
    prio_first = vec & (~vec + MAX_REQ'(1));
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink timebase: one-cycle tick every TICK_PSC clocks and a phase bit that toggles on each tick.
// tick is decoded combinationally from the prescaler, so it drops with reset immediately.
module led_tick_gen #(
  parameter int TICK_PSC = 256,
  parameter int PSC_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic phase
);

  logic [PSC_W-1:0] psc;

  assign tick = (psc == PSC_W'(TICK_PSC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      psc   <= '0;
      phase <= ~phase;
    end else begin
      psc   <= psc + PSC_W'(1);
    end
  end

endmodule

// File: rtl/led_status_arbiter.sv
// Shares the board LEDs between fixed-priority requesters with a minimum display hold.
// Grant and LED drive are registered together; idle display is a heartbeat on the top LED.
module led_status_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TICK_PSC   = 256,
  parameter int PSC_W      = 24,
  parameter int HOLD_TICKS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [LED_W*NUM_REQ-1:0] pat,
  input  logic [NUM_REQ-1:0]       blink,
  output logic [NUM_REQ-1:0]       grant,
  output logic [LED_W-1:0]         led,
  output logic                     tick,
  output logic                     busy
);

  localparam int HW = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, first;
  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic [LED_W-1:0]   pat_q, pat_nxt, pat_sel, led_nxt;
  logic               blink_q, blink_nxt, blink_sel;
  logic               phase, phase_nxt, hold_done;

  led_tick_gen #(
    .TICK_PSC (TICK_PSC),
    .PSC_W    (PSC_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .phase (phase)
  );

  assign first     = NUM_REQ'(prio_first(MAX_REQ'(req)));
  assign hold_done = (hold_cnt == HOLD_MAX);

  always_comb begin
    pat_sel   = '0;
    blink_sel = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (first[i]) begin
        pat_sel   = pat[LED_W*i +: LED_W];
        blink_sel = blink[i];
      end
    end
  end

  // Once the hold expires, the top-priority requester covers keep, preempt,
  // hand-over and release in a single comparison against the current grant.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    hold_nxt  = hold_cnt;
    pat_nxt   = pat_q;
    blink_nxt = blink_q;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = OWN;
          grant_nxt = first;
          hold_nxt  = '0;
          pat_nxt   = pat_sel;
          blink_nxt = blink_sel;
        end
      end
      OWN: begin
        if (!hold_done) begin
          if (tick) hold_nxt = hold_cnt + HW'(1);
        end else if (first == '0) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          hold_nxt  = '0;
        end else if (first != grant) begin
          grant_nxt = first;
          hold_nxt  = '0;
          pat_nxt   = pat_sel;
          blink_nxt = blink_sel;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // LED is computed from next-cycle phase so the registered value tracks phase exactly.
  always_comb begin
    phase_nxt = phase ^ tick;
    if (state_nxt == OWN) begin
      led_nxt = (blink_nxt && !phase_nxt) ? '0 : pat_nxt;
    end else begin
      led_nxt = {phase_nxt, {(LED_W-1){1'b0}}};
    end
  end

  assign busy = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      hold_cnt <= '0;
      pat_q    <= '0;
      blink_q  <= 1'b0;
      led      <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      hold_cnt <= hold_nxt;
      pat_q    <= pat_nxt;
      blink_q  <= blink_nxt;
      led      <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed per-cycle vectors for the LED arbiter (TICK_PSC=4, HOLD_TICKS=2), plus async reset sequence.
module tb_led_status_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [19:0] pat;
  logic [3:0]  blink;
  logic [3:0]  grant;
  logic [4:0]  led;
  logic        tick;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // {p3, p2, p1, p0}
  localparam logic [19:0] PB = {5'b00011, 5'b01010, 5'b11000, 5'b00111};
  localparam logic [19:0] PA = {5'b00011, 5'b01010, 5'b11000, 5'b11111};
  localparam logic [19:0] PC = {5'b00011, 5'b01010, 5'b11000, 5'b00001};

  typedef struct {
    logic [3:0]  req;
    logic [19:0] pat;
    logic [3:0]  blink;
    logic [3:0]  grant;
    logic [4:0]  led;
  } vec_t;

  vec_t tv[$];

  led_status_arbiter #(
    .NUM_REQ    (4),
    .TICK_PSC   (4),
    .PSC_W      (8),
    .HOLD_TICKS (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .pat   (pat),
    .blink (blink),
    .grant (grant),
    .led   (led),
    .tick  (tick),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input int n, input logic [3:0] r, input logic [19:0] p,
                     input logic [3:0] b, input logic [3:0] g, input logic [4:0] l);
    vec_t v;
    v.req = r; v.pat = p; v.blink = b; v.grant = g; v.led = l;
    repeat (n) tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    pat   = PB;
    blink = '0;

    // Idle heartbeat
    add(3, 4'b0000, PB, 4'b0000, 4'b0000, 5'b00000);
    add(4, 4'b0000, PB, 4'b0000, 4'b0000, 5'b10000);
    add(4, 4'b0000, PB, 4'b0000, 4'b0000, 5'b00000);
    add(4, 4'b0000, PB, 4'b0000, 4'b0000, 5'b10000);
    add(1, 4'b0000, PB, 4'b0000, 4'b0000, 5'b00000);
    // Single requester, dropped request held for 2 ticks
    add(1, 4'b0100, PB, 4'b0000, 4'b0100, 5'b01010);
    add(7, 4'b0000, PB, 4'b0000, 4'b0100, 5'b01010);
    add(2, 4'b0000, PB, 4'b0000, 4'b0000, 5'b00000);
    // Preemption by req0 deferred until hold expires
    add(2, 4'b0100, PB, 4'b0000, 4'b0100, 5'b01010);
    add(4, 4'b0101, PB, 4'b0000, 4'b0100, 5'b01010);
    add(1, 4'b0101, PB, 4'b0000, 4'b0001, 5'b00111);
    add(7, 4'b0000, PB, 4'b0000, 4'b0001, 5'b00111);
    add(1, 4'b0000, PB, 4'b0000, 4'b0000, 5'b00000);
    // Simultaneous requests, direct hand-over without idle cycle
    add(7, 4'b1010, PB, 4'b0000, 4'b0010, 5'b11000);
    add(2, 4'b1000, PB, 4'b0000, 4'b1000, 5'b00011);
    add(6, 4'b0000, PB, 4'b0000, 4'b1000, 5'b00011);
    add(1, 4'b0000, PB, 4'b0000, 4'b0000, 5'b00000);
    // Blinking owner; pattern change while owned is ignored
    add(2, 4'b0001, PA, 4'b0001, 4'b0001, 5'b00000);
    add(2, 4'b0001, PA, 4'b0001, 4'b0001, 5'b11111);
    add(2, 4'b0001, PC, 4'b0001, 4'b0001, 5'b11111);
    add(4, 4'b0001, PC, 4'b0001, 4'b0001, 5'b00000);
    add(4, 4'b0001, PC, 4'b0001, 4'b0001, 5'b11111);

    #3;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_led",   32'(led),   32'h0);
    chk("reset_tick",  32'(tick),  32'h0);
    chk("reset_busy",  32'(busy),  32'h0);
    @(posedge clk);
    #7 rst_n = 1'b1;

    for (int k = 1; k <= tv.size(); k++) begin
      req   = tv[k-1].req;
      pat   = tv[k-1].pat;
      blink = tv[k-1].blink;
      @(posedge clk);
      #1;
      chk($sformatf("grant@%0d", k), 32'(grant), 32'(tv[k-1].grant));
      chk($sformatf("led@%0d", k),   32'(led),   32'(tv[k-1].led));
      chk($sformatf("busy@%0d", k),  32'(busy),  32'(|tv[k-1].grant));
      chk($sformatf("tick@%0d", k),  32'(tick),  32'((k % 4) == 3));
      chk($sformatf("onehot@%0d", k), 32'($onehot0(grant)), 32'h1);
    end

    // Async reset between edges while owned and while tick is high
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_led",   32'(led),   32'h0);
    chk("midrst_tick",  32'(tick),  32'h0);
    chk("midrst_busy",  32'(busy),  32'h0);
    req   = '0;
    blink = '0;
    #2 rst_n = 1'b1;

    for (int j = 1; j <= 8; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_tick@%0d", j),  32'(tick),  32'((j % 4) == 3));
      chk($sformatf("post_led@%0d", j),   32'(led),   32'(((j >> 2) & 1) ? 5'b10000 : 5'b00000));
      chk($sformatf("post_grant@%0d", j), 32'(grant), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
